// File: rtl/wb_pkg.sv
// Shared constants and entry type for the register writeback unit.
package wb_pkg;
   localparam int WB_XLEN   = 32;
   localparam int WB_DEPTH  = 4;
   localparam int REG_COUNT = 32;
   localparam int RD_W      = 5;

   typedef struct packed {
      logic [RD_W-1:0]    rd;
      logic [WB_XLEN-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Dual-push, single-pop circular buffer of writeback entries.
// Push0 is always older than push1 when both are taken in the same cycle.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH,
   parameter int XLEN  = WB_XLEN,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push0,
   input  logic [RD_W-1:0]        push0_rd,
   input  logic [XLEN-1:0]        push0_data,
   input  logic                   push1,
   input  logic [RD_W-1:0]        push1_rd,
   input  logic [XLEN-1:0]        push1_data,
   input  logic                   pop,
   output logic [CW-1:0]          count,
   output logic [RD_W-1:0]        head_rd,
   output logic [XLEN-1:0]        head_data,
   output logic [DEPTH-1:0]       ent_valid,
   output logic [DEPTH*RD_W-1:0]  ent_rd,
   output logic [DEPTH*XLEN-1:0]  ent_data
);
   logic [RD_W-1:0] rd_q   [DEPTH];
   logic [XLEN-1:0] data_q [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   wr_ptr1;

   assign wr_ptr1 = wr_ptr + PW'(push0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr + PW'(pop);
         wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
         count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
      end
   end

   // Entry storage carries no reset; occupancy is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push0) begin
         rd_q[wr_ptr]   <= push0_rd;
         data_q[wr_ptr] <= push0_data;
      end
      if (push1) begin
         rd_q[wr_ptr1]   <= push1_rd;
         data_q[wr_ptr1] <= push1_data;
      end
   end

   assign head_rd   = rd_q[rd_ptr];
   assign head_data = data_q[rd_ptr];

   // Age-ordered view: slot 0 is the head, higher slots are younger.
   always_comb begin
      ent_valid = '0;
      ent_rd    = '0;
      ent_data  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         ent_valid[k]               = (CW'(k) < count);
         ent_rd[k*RD_W +: RD_W]     = rd_q[rd_ptr + PW'(k)];
         ent_data[k*XLEN +: XLEN]   = data_q[rd_ptr + PW'(k)];
      end
   end
endmodule

// File: rtl/reg_writeback_unit.sv
// Merges ALU and memory results into an in-order queue draining one register-file
// write per cycle, with a busy scoreboard for decode and a forwarding lookup.
module reg_writeback_unit
   import wb_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH,
   parameter int XLEN  = WB_XLEN
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 mem_valid,
   output logic                 mem_ready,
   input  logic [4:0]           mem_rd,
   input  logic [XLEN-1:0]      mem_data,
   input  logic                 alu_valid,
   output logic                 alu_ready,
   input  logic [4:0]           alu_rd,
   input  logic [XLEN-1:0]      alu_data,
   input  logic                 rsv_valid,
   output logic                 rsv_ready,
   input  logic [4:0]           rsv_rd,
   output logic [REG_COUNT-1:0] busy_mask,
   input  logic [4:0]           fwd_addr,
   output logic                 fwd_hit,
   output logic [XLEN-1:0]      fwd_data,
   output logic                 rf_write_en,
   output logic [4:0]           rf_write_addr,
   output logic [XLEN-1:0]      rf_write_data
);
   localparam int            CW      = $clog2(DEPTH + 1);
   localparam logic [CW:0]   DEPTH_C = DEPTH[CW:0];

   logic [CW-1:0]          count;
   logic [RD_W-1:0]        head_rd;
   logic [XLEN-1:0]        head_data;
   logic [DEPTH-1:0]       ent_valid;
   logic [DEPTH*RD_W-1:0]  ent_rd;
   logic [DEPTH*XLEN-1:0]  ent_data;

   logic                   pop;
   logic [CW:0]            used_after_pop;
   logic                   mem_fire;
   logic                   alu_fire;
   logic                   mem_enq;
   logic                   alu_enq;
   logic                   rsv_fire;
   logic [REG_COUNT-1:0]   busy_q;
   logic [REG_COUNT-1:0]   busy_set;
   logic [REG_COUNT-1:0]   busy_clr;

   // The head drains unconditionally; the register file never stalls.
   assign pop            = (count != '0);
   assign used_after_pop = {1'b0, count} - {{CW{1'b0}}, pop};

   assign mem_ready = (used_after_pop < DEPTH_C);
   assign mem_fire  = mem_valid & mem_ready;
   assign alu_ready = ((used_after_pop + {{CW{1'b0}}, mem_fire}) < DEPTH_C);
   assign alu_fire  = alu_valid & alu_ready;

   // x0 handshakes complete but never occupy a slot.
   assign mem_enq = mem_fire & (mem_rd != 5'd0);
   assign alu_enq = alu_fire & (alu_rd != 5'd0);

   wb_fifo #(
      .DEPTH (DEPTH),
      .XLEN  (XLEN)
   ) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push0      (mem_enq),
      .push0_rd   (mem_rd),
      .push0_data (mem_data),
      .push1      (alu_enq),
      .push1_rd   (alu_rd),
      .push1_data (alu_data),
      .pop        (pop),
      .count      (count),
      .head_rd    (head_rd),
      .head_data  (head_data),
      .ent_valid  (ent_valid),
      .ent_rd     (ent_rd),
      .ent_data   (ent_data)
   );

   assign rf_write_en   = pop;
   assign rf_write_addr = pop ? head_rd   : 5'd0;
   assign rf_write_data = pop ? head_data : '0;

   // Busy still reads set in the cycle its entry pops, so a same-rd reserve waits.
   assign rsv_ready = (rsv_rd == 5'd0) | ~busy_q[rsv_rd];
   assign rsv_fire  = rsv_valid & rsv_ready & (rsv_rd != 5'd0);

   always_comb begin
      busy_set = '0;
      busy_clr = '0;
      if (rsv_fire) busy_set[rsv_rd]  = 1'b1;
      if (pop)      busy_clr[head_rd] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= ((busy_q & ~busy_clr) | busy_set) & {{(REG_COUNT-1){1'b1}}, 1'b0};
      end
   end

   assign busy_mask = busy_q;

   // Scan oldest to youngest so the last match is the youngest value.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (ent_valid[k] && (ent_rd[k*RD_W +: RD_W] == fwd_addr) && (fwd_addr != 5'd0)) begin
            fwd_hit  = 1'b1;
            fwd_data = ent_data[k*XLEN +: XLEN];
         end
      end
   end
endmodule

// File: tb/tb_reg_writeback_unit.sv
// Bench for reg_writeback_unit: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model.
module tb_reg_writeback_unit;
   import wb_pkg::*;

   localparam int DEPTH = 4;
   localparam int XLEN  = 32;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             mem_valid, mem_ready;
   logic [4:0]       mem_rd;
   logic [XLEN-1:0]  mem_data;
   logic             alu_valid, alu_ready;
   logic [4:0]       alu_rd;
   logic [XLEN-1:0]  alu_data;
   logic             rsv_valid, rsv_ready;
   logic [4:0]       rsv_rd;
   logic [31:0]      busy_mask;
   logic [4:0]       fwd_addr;
   logic             fwd_hit;
   logic [XLEN-1:0]  fwd_data;
   logic             rf_write_en;
   logic [4:0]       rf_write_addr;
   logic [XLEN-1:0]  rf_write_data;

   always #5 clk = ~clk;

   reg_writeback_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .mem_valid     (mem_valid),
      .mem_ready     (mem_ready),
      .mem_rd        (mem_rd),
      .mem_data      (mem_data),
      .alu_valid     (alu_valid),
      .alu_ready     (alu_ready),
      .alu_rd        (alu_rd),
      .alu_data      (alu_data),
      .rsv_valid     (rsv_valid),
      .rsv_ready     (rsv_ready),
      .rsv_rd        (rsv_rd),
      .busy_mask     (busy_mask),
      .fwd_addr      (fwd_addr),
      .fwd_hit       (fwd_hit),
      .fwd_data      (fwd_data),
      .rf_write_en   (rf_write_en),
      .rf_write_addr (rf_write_addr),
      .rf_write_data (rf_write_data)
   );

   int          errors = 0;
   int          checks = 0;
   wb_entry_t   q[$];
   logic [31:0] busy_m;
   logic [31:0] pend;
   logic        mem_fire_m, alu_fire_m;
   logic        stall_seen;
   logic        pick_ok;
   logic [4:0]  pick_rd;
   int          nxt;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int used_after_pop();
      return q.size() - ((q.size() > 0) ? 1 : 0);
   endfunction

   function automatic logic exp_mem_ready();
      return used_after_pop() < DEPTH;
   endfunction

   function automatic logic exp_alu_ready();
      return (used_after_pop() + ((mem_valid && exp_mem_ready()) ? 1 : 0)) < DEPTH;
   endfunction

   function automatic logic exp_rsv_ready();
      return (rsv_rd == 5'd0) || !busy_m[rsv_rd];
   endfunction

   task automatic reset_model();
      q.delete();
      busy_m     = '0;
      pend       = '0;
      mem_fire_m = 1'b0;
      alu_fire_m = 1'b0;
      mem_valid  = 1'b0;
      alu_valid  = 1'b0;
      rsv_valid  = 1'b0;
   endtask

   task automatic compare_all();
      logic        hit;
      logic [31:0] fd;
      check("mem_ready", mem_ready, exp_mem_ready());
      check("alu_ready", alu_ready, exp_alu_ready());
      check("rsv_ready", rsv_ready, exp_rsv_ready());
      check("busy_mask", busy_mask, busy_m);
      if (q.size() > 0) begin
         check("wr_en",   rf_write_en,   1);
         check("wr_addr", rf_write_addr, q[0].rd);
         check("wr_data", rf_write_data, q[0].data);
      end else begin
         check("wr_en_idle",   rf_write_en,   0);
         check("wr_addr_idle", rf_write_addr, 0);
         check("wr_data_idle", rf_write_data, 0);
      end
      hit = 1'b0;
      fd  = '0;
      foreach (q[i]) begin
         if (fwd_addr != 5'd0 && q[i].rd == fwd_addr) begin
            hit = 1'b1;
            fd  = q[i].data;
         end
      end
      check("fwd_hit",  fwd_hit,  hit);
      check("fwd_data", fwd_data, fd);
      if (!alu_ready && mem_ready) stall_seen = 1'b1;
   endtask

   task automatic update_model();
      logic      pop_m, mr, ar, rr;
      wb_entry_t e;
      if (!reset_n) begin
         reset_model();
         return;
      end
      pop_m      = (q.size() > 0);
      mr         = exp_mem_ready();
      ar         = exp_alu_ready();
      rr         = exp_rsv_ready();
      mem_fire_m = mem_valid && mr;
      alu_fire_m = alu_valid && ar;
      if (pop_m) begin
         busy_m[q[0].rd] = 1'b0;
         q.delete(0);
      end
      if (rsv_valid && rr && rsv_rd != 5'd0) begin
         busy_m[rsv_rd] = 1'b1;
         pend[rsv_rd]   = 1'b1;
      end
      if (mem_fire_m && mem_rd != 5'd0) begin
         e.rd = mem_rd; e.data = mem_data;
         q.push_back(e);
         pend[mem_rd] = 1'b0;
      end
      if (alu_fire_m && alu_rd != 5'd0) begin
         e.rd = alu_rd; e.data = alu_data;
         q.push_back(e);
         pend[alu_rd] = 1'b0;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      update_model();
      #1;
      if (mem_fire_m) mem_valid = 1'b0;
      if (alu_fire_m) alu_valid = 1'b0;
   endtask

   task automatic pick_reg(output logic ok, output logic [4:0] r);
      int cand[$];
      for (int i = 1; i < 32; i++) if (pend[i]) cand.push_back(i);
      ok = 1'b0;
      r  = 5'd0;
      if ($urandom_range(0, 7) == 0) begin
         ok = 1'b1;
      end else if (cand.size() > 0) begin
         ok = 1'b1;
         r  = 5'(cand[$urandom_range(0, cand.size() - 1)]);
         pend[r] = 1'b0;
      end
   endtask

   // Producers may only write registers that decode has already reserved.
   always @(negedge clk) begin
      if (reset_n && mem_valid && mem_ready && mem_rd != 5'd0)
         assert (busy_mask[mem_rd]) else $error("protocol: mem push to unreserved x%0d", mem_rd);
      if (reset_n && alu_valid && alu_ready && alu_rd != 5'd0)
         assert (busy_mask[alu_rd]) else $error("protocol: alu push to unreserved x%0d", alu_rd);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      mem_rd = '0; mem_data = '0; alu_rd = '0; alu_data = '0;
      rsv_rd = '0; fwd_addr = '0;
      stall_seen = 1'b0;
      reset_model();

      repeat (3) cycle();
      reset_n = 1'b1;
      cycle();
      check("idle_en",        rf_write_en, 0);
      check("idle_busy",      busy_mask,   0);
      check("idle_mem_ready", mem_ready,   1);
      check("idle_alu_ready", alu_ready,   1);
      check("idle_fwd_hit",   fwd_hit,     0);

      // Single ALU write to x5
      rsv_valid = 1'b1; rsv_rd = 5'd5;
      cycle();
      rsv_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      cycle();
      check("x5_en",   rf_write_en,   1);
      check("x5_addr", rf_write_addr, 5);
      check("x5_data", rf_write_data, 32'hDEADBEEF);
      check("x5_busy", busy_mask[5],  1);
      cycle();
      check("x5_clr",  busy_mask[5],  0);
      check("x5_done", rf_write_en,   0);

      // Same-cycle mem and alu pushes keep mem older
      rsv_valid = 1'b1; rsv_rd = 5'd3;
      cycle();
      rsv_rd = 5'd4;
      cycle();
      rsv_valid = 1'b0;
      mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
      alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
      fwd_addr  = 5'd4;
      cycle();
      check("x3_first",  rf_write_addr, 3);
      check("x3_data",   rf_write_data, 32'h11);
      check("fwd4_hit",  fwd_hit,       1);
      check("fwd4_data", fwd_data,      32'h22);
      cycle();
      check("x4_second", rf_write_addr, 4);
      check("x4_data",   rf_write_data, 32'h22);
      cycle();
      fwd_addr = 5'd0;

      // Saturate the queue with both producers held valid
      rsv_valid = 1'b1;
      for (int r = 8; r < 24; r++) begin
         rsv_rd = 5'(r);
         cycle();
      end
      rsv_valid  = 1'b0;
      stall_seen = 1'b0;
      nxt = 8;
      for (int c = 0; c < 8; c++) begin
         if (!mem_valid && nxt < 24) begin
            mem_valid = 1'b1; mem_rd = 5'(nxt); mem_data = $urandom; nxt++;
         end
         if (!alu_valid && nxt < 24) begin
            alu_valid = 1'b1; alu_rd = 5'(nxt); alu_data = $urandom; nxt++;
         end
         cycle();
      end
      mem_valid = 1'b0; alu_valid = 1'b0;
      check("sat_stall_seen", stall_seen, 1);
      repeat (6) cycle();

      // WAW interlock on x7, then x0 reservation and push
      rsv_valid = 1'b1; rsv_rd = 5'd7;
      cycle();
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = $urandom;
      cycle();
      check("x7_blocked", rsv_ready, 0);
      cycle();
      check("x7_free", rsv_ready, 1);
      cycle();
      rsv_rd = 5'd0;
      #1;
      check("x0_rsv_ready", rsv_ready, 1);
      cycle();
      check("x0_busy_bit", busy_mask[0], 0);
      check("x7_still",    busy_mask[7], 1);
      rsv_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hCAFEF00D;
      cycle();
      check("x0_push_en", rf_write_en, 0);
      cycle();
      check("x0_push_en2", rf_write_en, 0);

      // Async reset with three entries queued
      rsv_valid = 1'b1;
      for (int r = 24; r < 28; r++) begin
         rsv_rd = 5'(r);
         cycle();
      end
      rsv_valid = 1'b0;
      mem_valid = 1'b1; mem_rd = 5'd24; mem_data = $urandom;
      alu_valid = 1'b1; alu_rd = 5'd25; alu_data = $urandom;
      cycle();
      mem_valid = 1'b1; mem_rd = 5'd26; mem_data = $urandom;
      alu_valid = 1'b1; alu_rd = 5'd27; alu_data = $urandom;
      cycle();
      check("pre_rst_en", rf_write_en, 1);
      #1 reset_n = 1'b0;
      #1;
      check("rst_en",        rf_write_en, 0);
      check("rst_busy",      busy_mask,   0);
      check("rst_mem_ready", mem_ready,   1);
      check("rst_alu_ready", alu_ready,   1);
      reset_model();
      repeat (2) cycle();
      reset_n = 1'b1;
      repeat (4) begin
         cycle();
         check("post_rst_en", rf_write_en, 0);
      end

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         rsv_valid = ($urandom_range(0, 2) == 0);
         rsv_rd    = 5'($urandom_range(0, 31));
         if (q.size() > 0 && $urandom_range(0, 1) == 1)
            fwd_addr = q[$urandom_range(0, q.size() - 1)].rd;
         else
            fwd_addr = 5'($urandom_range(0, 31));
         if (!mem_valid && $urandom_range(0, 1) == 1) begin
            pick_reg(pick_ok, pick_rd);
            if (pick_ok) begin
               mem_valid = 1'b1; mem_rd = pick_rd; mem_data = $urandom;
            end
         end
         if (!alu_valid && $urandom_range(0, 1) == 1) begin
            pick_reg(pick_ok, pick_rd);
            if (pick_ok) begin
               alu_valid = 1'b1; alu_rd = pick_rd; alu_data = $urandom;
            end
         end
         cycle();
      end
      rsv_valid = 1'b0; mem_valid = 1'b0; alu_valid = 1'b0;
      repeat (8) cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
